// File: rtl/fan_tach_monitor_if.sv
// Report bundle from the tach monitor to the BMC register file and power
// sequencing logic.
//
// Handshake: o_cnt_vld is a valid-only, single-cycle pulse with no ready.
// o_tach_cnt changes only in the cycle o_cnt_vld is high and then holds until
// the next pulse, so a consumer may sample it any time between pulses.
// o_fan_fail and o_any_fan_fail are level signals that settle one cycle after
// o_cnt_vld.
interface fan_tach_monitor_if #(
    parameter int FANNUMBER = 8,
    parameter int CNT_W     = 12
);
    logic [FANNUMBER*CNT_W-1:0] o_tach_cnt;
    logic                       o_cnt_vld;
    logic [FANNUMBER-1:0]       o_fan_fail;
    logic                       o_any_fan_fail;

    modport master (
        output o_tach_cnt,
        output o_cnt_vld,
        output o_fan_fail,
        output o_any_fan_fail
    );

    modport slave (
        input o_tach_cnt,
        input o_cnt_vld,
        input o_fan_fail,
        input o_any_fan_fail
    );
endinterface

// File: rtl/fan_tach_monitor.sv
// Fan tachometer monitor: synchronises and glitch-filters each fan's tach
// line, counts filtered rising edges over 1 s windows, and raises per-fan and
// aggregate fail flags after a run of low-count windows once spin-up blanking
// has expired.
module fan_tach_monitor #(
    parameter int FANNUMBER    = 8,
    parameter int CNT_W        = 12,
    parameter int FILT_US      = 4,
    parameter int MIN_PULSES   = 20,
    parameter int FAIL_WINDOWS = 3,
    parameter int BLANK_S      = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_1uSCE,
    input  logic                 i_1000mSCE,
    input  logic                 i_mon_en,
    input  logic [FANNUMBER-1:0] i_fan_tach,
    output logic [1:0]           o_mon_state,
    fan_tach_monitor_if.master   rpt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BLANK   = 2'd1,
        ST_MONITOR = 2'd2
    } mon_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_PULSES);
    localparam logic [3:0]       FILT_LIM   = 4'(FILT_US);
    localparam logic [2:0]       FAIL_LIM   = 3'(FAIL_WINDOWS);
    localparam logic [3:0]       BLANK_INIT = 4'(BLANK_S);

    logic [FANNUMBER-1:0]            sync1_q, sync2_q;
    logic [FANNUMBER-1:0]            filt_q, filt_dly_q;
    logic [FANNUMBER-1:0][3:0]       run_q;
    logic [FANNUMBER-1:0]            rise;
    logic [FANNUMBER-1:0][CNT_W-1:0] win_q, win_next, lat_q;
    logic                            vld_q;
    mon_state_t                      state_q, state_d;
    logic [3:0]                      blank_q, blank_d;
    logic                            eval_q;
    logic [FANNUMBER-1:0][2:0]       miss_q, miss_d;
    logic [FANNUMBER-1:0]            fail_q, fail_d;
    logic                            any_q;

    // Two-flop synchroniser for the asynchronous open-drain tach lines.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_fan_tach;
            sync2_q <= sync1_q;
        end
    end

    // Glitch filter: the level only flips after FILT_US consecutive
    // disagreeing 1 us samples; any agreeing sample restarts the run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            filt_q <= '0;
            run_q  <= '0;
        end else if (i_1uSCE) begin
            for (int n = 0; n < FANNUMBER; n++) begin
                if (sync2_q[n] == filt_q[n]) begin
                    run_q[n] <= '0;
                end else if (run_q[n] == FILT_LIM - 4'd1) begin
                    filt_q[n] <= ~filt_q[n];
                    run_q[n]  <= '0;
                end else begin
                    run_q[n] <= run_q[n] + 4'd1;
                end
            end
        end
    end

    // Delayed filtered level for rising-edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            filt_dly_q <= '0;
        end else begin
            filt_dly_q <= filt_q;
        end
    end

    assign rise = filt_q & ~filt_dly_q;

    // Saturating per-fan count including this cycle's rise, so a pulse that
    // lands on the window strobe is folded into the closing window.
    always_comb begin
        win_next = win_q;
        for (int n = 0; n < FANNUMBER; n++) begin
            if (rise[n] && (win_q[n] != CNT_MAX)) begin
                win_next[n] = win_q[n] + CNT_W'(1);
            end
        end
    end

    // Window counters: latch and restart on the 1 s strobe, in every state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            win_q <= '0;
            lat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= i_1000mSCE;
            if (i_1000mSCE) begin
                lat_q <= win_next;
                win_q <= '0;
            end else begin
                win_q <= win_next;
            end
        end
    end

    // Monitor FSM next state: disable always wins; blanking counts down on
    // 1 s strobes before monitoring starts.
    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        if (!i_mon_en) begin
            state_d = ST_IDLE;
            blank_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (BLANK_INIT == 4'd0) begin
                        state_d = ST_MONITOR;
                    end else begin
                        state_d = ST_BLANK;
                        blank_d = BLANK_INIT;
                    end
                end
                ST_BLANK: begin
                    if (i_1000mSCE) begin
                        if (blank_q <= 4'd1) begin
                            state_d = ST_MONITOR;
                            blank_d = '0;
                        end else begin
                            blank_d = blank_q - 4'd1;
                        end
                    end
                end
                ST_MONITOR: begin
                    state_d = ST_MONITOR;
                end
                default: begin
                    state_d = ST_IDLE;
                    blank_d = '0;
                end
            endcase
        end
    end

    // Monitor FSM state register; eval_q marks the o_cnt_vld cycle of a
    // window that closed while already monitoring.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            blank_q <= '0;
            eval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            eval_q  <= i_1000mSCE && i_mon_en && (state_q == ST_MONITOR);
        end
    end

    // Fail evaluation: consecutive low windows saturate the miss counter and
    // set the flag; one healthy window clears both. Disable clears everything.
    always_comb begin
        miss_d = miss_q;
        fail_d = fail_q;
        if (!i_mon_en || (state_q == ST_IDLE)) begin
            miss_d = '0;
            fail_d = '0;
        end else if (eval_q) begin
            for (int n = 0; n < FANNUMBER; n++) begin
                if (lat_q[n] < MIN_CNT) begin
                    if (miss_q[n] != FAIL_LIM) begin
                        miss_d[n] = miss_q[n] + 3'd1;
                    end
                    if (miss_d[n] == FAIL_LIM) begin
                        fail_d[n] = 1'b1;
                    end
                end else begin
                    miss_d[n] = '0;
                    fail_d[n] = 1'b0;
                end
            end
        end
    end

    // Fail flag registers, aggregate flag updated in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            miss_q <= '0;
            fail_q <= '0;
            any_q  <= 1'b0;
        end else begin
            miss_q <= miss_d;
            fail_q <= fail_d;
            any_q  <= |fail_d;
        end
    end

    assign rpt.o_tach_cnt     = lat_q;
    assign rpt.o_cnt_vld      = vld_q;
    assign rpt.o_fan_fail     = fail_q;
    assign rpt.o_any_fan_fail = any_q;
    assign o_mon_state        = state_q;

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Bench for fan_tach_monitor: directed and randomized tach windows checked
// against a window-level model (pulse arithmetic plus a history of low
// windows per fan).
module tb_fan_tach_monitor;

    localparam int FANNUMBER    = 8;
    localparam int CNT_W        = 12;
    localparam int FILT_US      = 4;
    localparam int MIN_PULSES   = 20;
    localparam int FAIL_WINDOWS = 3;
    localparam int BLANK_S      = 5;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_1uSCE;
    logic                 i_1000mSCE;
    logic                 i_mon_en;
    logic [FANNUMBER-1:0] i_fan_tach;
    logic [1:0]           o_mon_state;

    fan_tach_monitor_if #(.FANNUMBER(FANNUMBER), .CNT_W(CNT_W)) rpt_if ();

    fan_tach_monitor #(
        .FANNUMBER(FANNUMBER), .CNT_W(CNT_W), .FILT_US(FILT_US),
        .MIN_PULSES(MIN_PULSES), .FAIL_WINDOWS(FAIL_WINDOWS), .BLANK_S(BLANK_S)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_1uSCE(i_1uSCE),
        .i_1000mSCE(i_1000mSCE),
        .i_mon_en(i_mon_en),
        .i_fan_tach(i_fan_tach),
        .o_mon_state(o_mon_state),
        .rpt(rpt_if)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus shape per fan: pulse count, high/low widths in us, start offset.
    int us_div   = 2;
    int cyc      = 0;
    int late_fan = -1;
    int p     [FANNUMBER];
    int hi_us [FANNUMBER];
    int lo_us [FANNUMBER];
    int st    [FANNUMBER];

    // Scoreboard and monitor model.
    logic [CNT_W-1:0]     exp_q[$];
    logic [FANNUMBER-1:0] low_hist[$];
    bit                   en_m    = 1'b0;
    int                   strobes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        i_1uSCE = ((cyc % us_div) == 0);
        cyc++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_all(input int pp, input int hh, input int ll);
        for (int f = 0; f < FANNUMBER; f++) begin
            p[f] = pp; hi_us[f] = hh; lo_us[f] = ll; st[f] = f;
        end
    endtask

    task automatic set_mon(input bit en);
        i_mon_en = en;
        en_m     = en;
        strobes  = 0;
        low_hist.delete();
    endtask

    // One window of tach activity ending with a 1 s strobe, then checks of
    // latched counts, valid pulse, fail flags and FSM state.
    task automatic run_window(input string tag);
        int len, span, per, pos, n;
        bit mon_before;
        logic [FANNUMBER-1:0] low, exp_fail;
        logic [1:0] exp_state;
        len = 64;
        for (int f = 0; f < FANNUMBER; f++) begin
            span = st[f] + p[f] * (hi_us[f] + lo_us[f]) * us_div;
            if (span + 40 > len) len = span + 40;
        end
        for (int c = 0; c < len; c++) begin
            for (int f = 0; f < FANNUMBER; f++) begin
                per = (hi_us[f] + lo_us[f]) * us_div;
                pos = c - st[f];
                i_fan_tach[f] = (pos >= 0) && (pos < p[f] * per) && ((pos % per) < hi_us[f] * us_div);
                if ((f == late_fan) && (c >= len - 7) && (c < len - 3)) i_fan_tach[f] = 1'b1;
            end
            i_1000mSCE = (c == len - 1);
            step();
        end
        // Expected window counts from the pulse description.
        for (int f = 0; f < FANNUMBER; f++) begin
            n = (hi_us[f] >= FILT_US) ? p[f] : 0;
            if (f == late_fan) n++;
            if (n > CNT_MAX) n = CNT_MAX;
            exp_q.push_back(CNT_W'(n));
            low[f] = (n < MIN_PULSES);
        end
        check({tag, "_vld_hi"}, 32'(rpt_if.o_cnt_vld), 1);
        for (int f = 0; f < FANNUMBER; f++) begin
            check($sformatf("%s_cnt%0d", tag, f), 32'(rpt_if.o_tach_cnt[f*CNT_W +: CNT_W]), 32'(exp_q.pop_front()));
        end
        // Fail model: a fan fails when its last FAIL_WINDOWS monitored windows were all low.
        mon_before = en_m && (strobes >= BLANK_S);
        if (en_m) strobes++;
        if (mon_before) low_hist.push_back(low);
        exp_fail = '0;
        if (en_m && (low_hist.size() >= FAIL_WINDOWS)) begin
            exp_fail = '1;
            for (int k = 0; k < FAIL_WINDOWS; k++) exp_fail &= low_hist[low_hist.size() - 1 - k];
        end
        exp_state = !en_m ? 2'd0 : ((strobes >= BLANK_S) ? 2'd2 : 2'd1);
        i_1000mSCE = 1'b0;
        i_fan_tach = '0;
        step();
        check({tag, "_vld_lo"}, 32'(rpt_if.o_cnt_vld), 0);
        check({tag, "_fail"}, 32'(rpt_if.o_fan_fail), 32'(exp_fail));
        check({tag, "_any"}, 32'(rpt_if.o_any_fan_fail), 32'(|exp_fail));
        check({tag, "_state"}, 32'(o_mon_state), 32'(exp_state));
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_cnt"}, 32'(rpt_if.o_tach_cnt == '0), 1);
        check({tag, "_vld"}, 32'(rpt_if.o_cnt_vld), 0);
        check({tag, "_fail"}, 32'(rpt_if.o_fan_fail), 0);
        check({tag, "_any"}, 32'(rpt_if.o_any_fan_fail), 0);
        check({tag, "_state"}, 32'(o_mon_state), 0);
    endtask

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle windows.
        i_rst = 1'b1; i_1uSCE = 1'b0; i_1000mSCE = 1'b0; i_mon_en = 1'b0; i_fan_tach = '0;
        set_all(0, 4, 4);
        repeat (3) step();
        check_all_reset("reset");
        i_rst = 1'b0;
        run_window("idle0");
        run_window("idle1");

        // Counting: fan0 at 100 pulses per window.
        set_all(0, 4, 4);
        p[0] = 100; hi_us[0] = 5; lo_us[0] = 5;
        run_window("count100");

        // Glitch rejection on fan1: 1 us and 3 us spikes, then 6 us pulses.
        set_all(0, 4, 4);
        p[1] = 50; hi_us[1] = 1; lo_us[1] = 8;
        run_window("glitch1");
        hi_us[1] = 3;
        run_window("glitch3");
        hi_us[1] = 6;
        run_window("glitch6");

        // Randomized windows while monitoring is off.
        for (int w = 0; w < 6; w++) begin
            for (int f = 0; f < FANNUMBER; f++) begin
                p[f] = $urandom_range(0, 30); hi_us[f] = $urandom_range(1, 7);
                lo_us[f] = $urandom_range(4, 8); st[f] = $urandom_range(0, 20);
            end
            run_window($sformatf("rand%0d", w));
        end

        // Blanking then fan2 failure.
        set_all(25, 4, 4);
        p[2] = 0;
        set_mon(1'b1);
        for (int w = 0; w < BLANK_S + FAIL_WINDOWS; w++) run_window($sformatf("blank%0d", w));
        check("fail2_set", 32'(rpt_if.o_fan_fail), 32'h04);
        p[2] = 25;
        run_window("fan2_restart");
        p[2] = 0;
        for (int w = 0; w < FAIL_WINDOWS; w++) run_window($sformatf("refail%0d", w));

        // Disable while fan2 is failed.
        i_mon_en = 1'b0;
        step();
        step();
        set_mon(1'b0);
        check("dis_fail", 32'(rpt_if.o_fan_fail), 0);
        check("dis_any", 32'(rpt_if.o_any_fan_fail), 0);
        check("dis_state", 32'(o_mon_state), 0);

        // Threshold boundary on fan3: 20 is healthy, 19 is low.
        set_all(25, 4, 4);
        p[3] = MIN_PULSES;
        set_mon(1'b1);
        for (int w = 0; w < BLANK_S + FAIL_WINDOWS; w++) run_window($sformatf("b20_%0d", w));
        p[3] = MIN_PULSES - 1;
        for (int w = 0; w < FAIL_WINDOWS; w++) run_window($sformatf("b19_%0d", w));
        set_mon(1'b0);
        run_window("b_off");

        // Pulse coincident with the 1 s strobe lands in the closing window.
        us_div = 1;
        set_all(0, 4, 4);
        p[4] = 3;
        late_fan = 4;
        run_window("coinc");
        late_fan = -1;
        p[4] = 0;
        run_window("coinc_next");

        // Saturation of the window counter.
        set_all(0, 4, 4);
        p[5] = 4200;
        run_window("sat");
        us_div = 2;

        // Reset in the middle of a window discards the partial count.
        i_1000mSCE = 1'b0;
        for (int c = 0; c < 200; c++) begin
            i_fan_tach[6] = ((c % 16) < 8);
            step();
        end
        i_fan_tach = '0;
        i_rst = 1'b1;
        repeat (3) step();
        check_all_reset("midrst");
        i_rst = 1'b0;
        set_all(0, 4, 4);
        run_window("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fan_tach_monitor.md
Name: fan_tach_monitor

Overview:
- Measures tachometer feedback from the fans driven by the fan PWM controller. Each fan's tach line is synchronised, glitch-filtered and rising-edge counted over 1 s windows.
- Per-fan counts and per-fan/aggregate fan-fail flags are published for the BMC register file and power sequencing logic.
- Sits directly downstream of the fan PWM stage and shares its 1 µs and 1 s clock-enable strobes.

Parameters:
- FANNUMBER, 8, number of fans/tach inputs.
- CNT_W, 12, width of each per-fan pulse counter; saturates at 2^CNT_W-1.
- FILT_US, 4, consecutive identical 1 µs samples required to change the filtered tach level (1..15).
- MIN_PULSES, 20, minimum pulses per 1 s window for a healthy fan.
- FAIL_WINDOWS, 3, consecutive low windows before a fan is declared failed (1..7).
- BLANK_S, 5, spin-up blanking windows after monitoring is enabled (0..15).

Ports:
- i_clk, input, 1, system clock.
- i_rst, input, 1, synchronous active-high reset.
- i_1uSCE, input, 1, single-cycle 1 µs clock-enable strobe.
- i_1000mSCE, input, 1, single-cycle 1 s clock-enable strobe.
- i_mon_en, input, 1, fans powered and monitoring permitted (from power-on state).
- i_fan_tach, input, FANNUMBER, asynchronous open-drain tach inputs.
- o_tach_cnt, output, FANNUMBER*CNT_W, latched counts of the last completed window; fan n occupies bits [n*CNT_W +: CNT_W].
- o_cnt_vld, output, 1, one-cycle pulse when o_tach_cnt updates.
- o_fan_fail, output, FANNUMBER, per-fan fail flags.
- o_any_fan_fail, output, 1, OR of o_fan_fail.
- o_mon_state, output, 2, FSM state: 0 IDLE, 1 BLANK, 2 MONITOR.

Behaviour:
- Clocking and reset: one clock domain (i_clk); synchronous active-high reset (i_rst).
- Reset values: o_tach_cnt 0, o_cnt_vld 0, o_fan_fail 0, o_any_fan_fail 0, o_mon_state IDLE. All internal counters, filters and synchronisers reset to 0.
- Synchroniser: 2-flop synchroniser per tach bit, clocked every i_clk.
- Glitch filter:
  - Per-fan filtered level plus a 4-bit run counter, advanced only on i_1uSCE.
  - If the synced sample equals the filtered level, the run counter clears.
  - Otherwise the run counter increments. When it reaches FILT_US, the filtered level toggles and the run counter clears.
- Edge detect: a filtered 0->1 transition produces a one-cycle rise pulse per fan.
- Window counter:
  - Per-fan counter increments on each rise pulse and saturates at all-ones.
  - On i_1000mSCE, every counter's current value (including a rise pulse in that same cycle) is copied to o_tach_cnt.
  - In that same i_1000mSCE cycle the counter reloads to 0. No pulse is lost or double-counted.
  - o_cnt_vld asserts in the cycle after i_1000mSCE, for one cycle.
  - Counting and latching run in all FSM states.
- FSM:
  - IDLE: fail logic frozen, miss counters cleared. i_mon_en=1 -> BLANK, blank counter loaded with BLANK_S.
  - BLANK: each i_1000mSCE decrements the blank counter. When it reaches 0 (or immediately if BLANK_S=0) -> MONITOR.
  - MONITOR: on each o_cnt_vld cycle, every fan is evaluated against MIN_PULSES (see Fail logic).
  - i_mon_en=0 in any state -> IDLE on the next cycle. This also clears o_fan_fail, so power-off is not treated as a fan fault.
- Fail logic, per fan, with a 3-bit miss counter:
  - Latched count < MIN_PULSES: miss counter increments, saturating at FAIL_WINDOWS.
  - Miss counter reaching FAIL_WINDOWS sets o_fan_fail.
  - Latched count >= MIN_PULSES: miss counter clears and o_fan_fail clears in the same cycle.
  - Fail flags are registered, valid one cycle after o_cnt_vld. o_any_fan_fail is registered in the same cycle as o_fan_fail.
- Simultaneous events:
  - i_mon_en falling in the same cycle as o_cnt_vld: the IDLE transition wins and no evaluation occurs.
  - i_1000mSCE and i_1uSCE together: both are processed normally.
- Reset mid-window: all state discards to reset values and the partial window is lost.

Test Plan:
- Reset + idle: assert i_rst 3 cycles, no tach activity -> all outputs 0, o_mon_state=0. After 2 s windows, o_tach_cnt=0 and o_cnt_vld pulses twice.
- Counting: fan0 tach 100 Hz square wave (5 ms high/low), i_mon_en=0 -> fan0 count 100±1 per window; other fans 0; no fail flags.
- Glitch rejection: fan1 1 µs-wide and 3 µs-wide high spikes at 50 Hz, FILT_US=4 -> fan1 count 0. Widen spikes to 6 µs -> count 50±1.
- Blanking + fail:
  - i_mon_en=1, fan2 stopped, others 100 Hz, BLANK_S=5 -> state BLANK for 5 windows, then MONITOR.
  - o_fan_fail[2] sets after 3 further windows; o_any_fan_fail=1; other bits 0.
  - Fan2 restarts at 100 Hz -> fail bit clears after the next window.
- Disable mid-fail: with o_fan_fail[2]=1, drop i_mon_en -> o_fan_fail=0 and o_mon_state=IDLE within 2 cycles.
- Boundary: fan3 exactly 20 pulses/window -> no fail. 19 pulses/window -> fail after the 3rd window. 5000 pulses/window with CNT_W=12 -> count saturates at 4095. Pulse coincident with i_1000mSCE is counted in the closing window.
